// File: rtl/hex_display_scheduler_pkg.sv
// Shared constants for the HEX display scheduler: default geometry, active-low
// 7-segment patterns (bit 6 = g ... bit 0 = a) and the nibble decoder.
package hex_sched_pkg;

    localparam int NREQ_DEF   = 4;
    localparam int NDIG_DEF   = 8;
    localparam int DIG_W_DEF  = 3;
    localparam int TICK_W_DEF = 25;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;

    function automatic logic [6:0] nibble_to_seg(input logic [3:0] nib, input logic blank);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = SEG_A;
            4'hB:    seg = SEG_B;
            4'hC:    seg = SEG_C;
            4'hD:    seg = SEG_D;
            4'hE:    seg = SEG_E;
            default: seg = SEG_F;
        endcase
        return blank ? SEG_BLANK : seg;
    endfunction

endpackage

// File: rtl/hex_display_scheduler_if.sv
// Requester-side write port of the HEX display scheduler: per-requester
// (digit, nibble, blank) records with a req/ack handshake.
interface hex_display_scheduler_if
    import hex_sched_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int DIG_W = DIG_W_DEF
);
    logic [NREQ-1:0]       req;
    logic [NREQ*DIG_W-1:0] req_digit;
    logic [NREQ*4-1:0]     req_value;
    logic [NREQ-1:0]       req_blank;
    logic [NREQ-1:0]       ack;

    modport master (
        output req,
        output req_digit,
        output req_value,
        output req_blank,
        input  ack
    );

    modport slave (
        input  req,
        input  req_digit,
        input  req_value,
        input  req_blank,
        output ack
    );
endinterface

// File: rtl/hex_display_scheduler_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant scanning upward from a
// pointer that moves just past the winner whenever advance is high.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr_reg;
    logic [PTR_W-1:0] ptr_next;
    logic             found;
    int               idx;

    always_comb begin
        grant    = '0;
        ptr_next = ptr_reg;
        found    = 1'b0;
        idx      = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr_reg) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                ptr_next   = (idx == N - 1) ? '0 : PTR_W'(idx + 1);
            end
        end
        if (!advance) begin
            ptr_next = ptr_reg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end
endmodule

// File: rtl/hex_display_scheduler.sv
// Shares an NDIG-digit HEX display between NREQ requesters via a shadow store
// refreshed to the panel on a divider tick. Optional disp_seg: HEX_SEG_DECODE_EN.
module hex_display_scheduler
    import hex_sched_pkg::*;
#(
    parameter int NREQ   = NREQ_DEF,
    parameter int NDIG   = NDIG_DEF,
    parameter int DIG_W  = DIG_W_DEF,
    parameter int TICK_W = TICK_W_DEF
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET,
    hex_display_scheduler_if.slave bus,
    output logic                  tick,
    output logic [NDIG*4-1:0]     disp_value,
`ifdef HEX_SEG_DECODE_EN
    output logic [NDIG*7-1:0]     disp_seg,
`endif
    output logic [NDIG-1:0]       disp_blank
);
    logic [NREQ-1:0]   req_eff;
    logic [NREQ-1:0]   grant;
    logic              wr_en;
    logic [DIG_W-1:0]  wr_digit;
    logic [3:0]        wr_value;
    logic              wr_blank;
    logic [TICK_W-1:0] tick_cnt_reg;
    logic              tick_reg;
    logic              tick_wrap;

    // Requests are masked while RESET is high so ack drops immediately.
    assign req_eff = RESET ? '0 : bus.req;

    rr_arbiter #(
        .N(NREQ)
    ) u_arb (
        .clk     (CLOCK_50),
        .rst     (RESET),
        .req     (req_eff),
        .advance (|req_eff),
        .grant   (grant)
    );

    assign bus.ack = grant;
    assign wr_en   = |grant;

    always_comb begin
        wr_digit = '0;
        wr_value = '0;
        wr_blank = 1'b0;
        for (int r = 0; r < NREQ; r++) begin
            if (grant[r]) begin
                wr_digit = bus.req_digit[r*DIG_W +: DIG_W];
                wr_value = bus.req_value[r*4 +: 4];
                wr_blank = bus.req_blank[r];
            end
        end
    end

    assign tick_wrap = &tick_cnt_reg;

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            tick_cnt_reg <= '0;
            tick_reg     <= 1'b0;
        end else begin
            tick_cnt_reg <= tick_cnt_reg + 1'b1;
            tick_reg     <= tick_wrap;
        end
    end

    assign tick = tick_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NDIG; gi++) begin : g_digit
            logic [3:0] shadow_value_reg;
            logic       shadow_blank_reg;
            logic [3:0] disp_value_reg;
            logic       disp_blank_reg;
            logic       hit;

            assign hit = wr_en && (wr_digit == DIG_W'(gi));

            // Display copies the pre-write shadow when a write lands on a tick edge.
            always_ff @(posedge CLOCK_50 or posedge RESET) begin
                if (RESET) begin
                    shadow_value_reg <= 4'h0;
                    shadow_blank_reg <= 1'b1;
                    disp_value_reg   <= 4'h0;
                    disp_blank_reg   <= 1'b1;
                end else begin
                    if (tick_wrap) begin
                        disp_value_reg <= shadow_value_reg;
                        disp_blank_reg <= shadow_blank_reg;
                    end
                    if (hit) begin
                        if (wr_blank) begin
                            shadow_blank_reg <= 1'b1;
                        end else begin
                            shadow_value_reg <= wr_value;
                            shadow_blank_reg <= 1'b0;
                        end
                    end
                end
            end

            assign disp_value[gi*4 +: 4] = disp_value_reg;
            assign disp_blank[gi]        = disp_blank_reg;

`ifdef HEX_SEG_DECODE_EN
            logic [6:0] disp_seg_reg;

            always_ff @(posedge CLOCK_50 or posedge RESET) begin
                if (RESET) begin
                    disp_seg_reg <= SEG_BLANK;
                end else if (tick_wrap) begin
                    disp_seg_reg <= nibble_to_seg(shadow_value_reg, shadow_blank_reg);
                end
            end

            assign disp_seg[gi*7 +: 7] = disp_seg_reg;
`endif
        end
    endgenerate
endmodule
